// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums each group of DEPTH_F products into one psum and flags the last window of a row.
// Optional build macro PSUM_ACC_SATURATE_EN clamps additions to the accumulator maximum instead of wrapping.
module psum_accumulator #(
    parameter int PROD_WIDTH = 8,
    parameter int ACC_WIDTH  = 12,
    parameter int DEPTH_F    = 3,
    parameter int NUM_OUT    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [ACC_WIDTH-1:0]  psum_data,
    output logic                  psum_valid,
    input  logic                  psum_ready,
    output logic                  psum_last,
    output logic                  busy
);

    localparam int WIN_W = $clog2(DEPTH_F + 1);
    localparam int ROW_W = $clog2(NUM_OUT + 1);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DEPTH_F - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_OUT - 1);

    logic [0:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] psum_q, psum_d;
    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;

    logic                 prod_hs;
    logic                 psum_hs;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] acc_new;

    // Valid/ready: a transfer happens on any rising edge where both are high; ready and valid depend on state only.
    assign prod_ready = (state_q == ST_ACC);
    assign psum_valid = (state_q == ST_OUT);
    assign prod_hs    = prod_valid && prod_ready;
    assign psum_hs    = psum_valid && psum_ready;

    assign psum_data  = psum_q;
    assign psum_last  = psum_valid && (row_cnt_q == ROW_LAST);
    assign busy       = (win_cnt_q != '0);

    always_comb begin
        prod_ext = ACC_WIDTH'(prod_data);
        sum_ext  = {1'b0, acc_q} + {1'b0, prod_ext};
`ifdef PSUM_ACC_SATURATE_EN
        // A clamped value stays clamped: any further non-zero add carries out again.
        acc_sum = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
        acc_sum = sum_ext[ACC_WIDTH-1:0];
`endif
        acc_new = (win_cnt_q == '0) ? prod_ext : acc_sum;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        psum_d    = psum_q;
        win_cnt_d = win_cnt_q;
        row_cnt_d = row_cnt_q;

        if (prod_hs) begin
            acc_d = acc_new;
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d = '0;
                psum_d    = acc_new;
                state_d   = ST_OUT;
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
            end
        end

        if (psum_hs) begin
            state_d   = ST_ACC;
            row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            psum_q    <= '0;
            win_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            psum_q    <= psum_d;
            win_cnt_q <= win_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: expected psums queued at stimulus time, checked on each output handshake.
module tb_psum_accumulator;

    localparam int PW = 8;
    localparam int AW = 12;
    localparam int OW = 9;
    localparam int NO = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] prod_data;
    logic          prod_valid;
    logic          prod_ready;
    logic [AW-1:0] psum_data;
    logic          psum_valid;
    logic          psum_ready;
    logic          psum_last;
    logic          busy;

    logic [PW-1:0] o_prod_data;
    logic          o_prod_valid;
    logic          o_prod_ready;
    logic [OW-1:0] o_psum_data;
    logic          o_psum_valid;
    logic          o_psum_ready;
    logic          o_psum_last;
    logic          o_busy;

    int total = 0;
    int bad = 0;
    int hs_count = 0;
    int m_row = 0;
    logic [AW:0] exp_q[$];

    always #5 clk = ~clk;

    psum_accumulator u_dut (
        .clk        (clk),
        .reset      (reset),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .psum_data  (psum_data),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_last  (psum_last),
        .busy       (busy)
    );

    psum_accumulator #(.ACC_WIDTH(OW)) u_ovf (
        .clk        (clk),
        .reset      (reset),
        .prod_data  (o_prod_data),
        .prod_valid (o_prod_valid),
        .prod_ready (o_prod_ready),
        .psum_data  (o_psum_data),
        .psum_valid (o_psum_valid),
        .psum_ready (o_psum_ready),
        .psum_last  (o_psum_last),
        .busy       (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int sum);
        logic last;
        last = (m_row == NO - 1);
        exp_q.push_back({last, AW'(sum)});
        m_row = (m_row + 1) % NO;
    endtask

    task automatic send(input int d);
        int n;
        n = 0;
        prod_data  = PW'(d);
        prod_valid = 1'b1;
        while (prod_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", prod_ready, 1);
        @(posedge clk); #1;
        prod_valid = 1'b0;
    endtask

    task automatic o_send(input int d);
        int n;
        n = 0;
        o_prod_data  = PW'(d);
        o_prod_valid = 1'b1;
        while (o_prod_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ovf_send_ready", o_prod_ready, 1);
        @(posedge clk); #1;
        o_prod_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_psum_valid", psum_valid, 0);
        check("rst_psum_data", psum_data, 0);
        check("rst_psum_last", psum_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_row = 0;
        exp_q.delete();
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_prod_ready", prod_ready, 1);
    endtask

    always @(negedge clk) begin : monitor
        logic [AW:0] e;
        if (reset === 1'b0 && psum_valid === 1'b1 && psum_ready === 1'b1) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                check("psum_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("psum_data", psum_data, e[AW-1:0]);
                check("psum_last", psum_last, e[AW]);
            end
        end
    end

    initial begin
        int hs0;
        logic [OW-1:0] ovf_exp;

        reset        = 1'b1;
        prod_data    = '0;
        prod_valid   = 1'b0;
        psum_ready   = 1'b1;
        o_prod_data  = '0;
        o_prod_valid = 1'b0;
        o_psum_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("init_psum_valid", psum_valid, 0);
        check("init_psum_data", psum_data, 0);
        check("init_psum_last", psum_last, 0);
        check("init_busy", busy, 0);
        reset = 1'b0;
        #1;
        check("init_prod_ready", prod_ready, 1);

        // Basic window
        push_exp(1 + 4 + 9);
        send(1);
        check("basic_busy", busy, 1);
        send(4);
        send(9);
        check("basic_latency_valid", psum_valid, 1);
        check("basic_out_prod_ready", prod_ready, 0);
        check("basic_out_busy", busy, 0);
        wait_drain();

        // Full row, then wrap of the row counter
        do_reset();
        push_exp(0 + 1 + 4);  send(0); send(1); send(4);
        push_exp(1 + 4 + 9);  send(1); send(4); send(9);
        push_exp(4 + 9 + 16); send(4); send(9); send(16);
        push_exp(1 + 1 + 1);  send(1); send(1); send(1);
        wait_drain();

        // Backpressure with a product pending upstream
        psum_ready = 1'b0;
        push_exp(2 + 3 + 5);
        send(2); send(3); send(5);
        prod_data  = 8'd7;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_psum_valid", psum_valid, 1);
            check("bp_psum_data", psum_data, 10);
            check("bp_prod_ready", prod_ready, 0);
            @(posedge clk); #1;
        end
        push_exp(7 + 1 + 1);
        psum_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", prod_ready, 1);
        check("bp_release_busy", busy, 0);
        @(posedge clk); #1;
        check("bp_seven_taken", busy, 1);
        prod_valid = 1'b0;
        send(1); send(1);
        wait_drain();

        // Overflow on a 9-bit accumulator
`ifdef PSUM_ACC_SATURATE_EN
        ovf_exp = 9'd511;
`else
        ovf_exp = OW'(255 * 3);
`endif
        o_send(255); o_send(255); o_send(255);
        check("ovf_valid", o_psum_valid, 1);
        check("ovf_data", o_psum_data, ovf_exp);
        check("ovf_last", o_psum_last, 0);
        @(posedge clk); #1;
        check("ovf_back_to_acc", o_prod_ready, 1);

        // Reset mid-window after advancing the row counter
        push_exp(1 + 1 + 1); send(1); send(1); send(1);
        wait_drain();
        send(6); send(6);
        check("mid_busy", busy, 1);
        do_reset();
        push_exp(1 + 2 + 3); send(1); send(2); send(3);
        push_exp(2 + 2 + 2); send(2); send(2); send(2);
        push_exp(3 + 3 + 3); send(3); send(3); send(3);
        wait_drain();

        // Reset while a psum is waiting
        psum_ready = 1'b0;
        send(5); send(5); send(5);
        check("out_valid_before_rst", psum_valid, 1);
        hs0 = hs_count;
        #2;
        reset = 1'b1;
        #1;
        check("out_rst_valid", psum_valid, 0);
        check("out_rst_data", psum_data, 0);
        check("out_rst_last", psum_last, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_row = 0;
        exp_q.delete();
        psum_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("out_rst_no_hs", hs_count, hs0);
        check("out_rst_valid_after", psum_valid, 0);
        check("out_rst_prod_ready", prod_ready, 1);
        push_exp(4 + 4 + 4); send(4); send(4); send(4);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Clocked partial-sum accumulator sitting directly downstream of the multiplier stage in the convolution PE. It takes one product per handshake, sums each consecutive group of DEPTH_F products (one filter window), and emits one partial sum per window. It also counts windows so the consumer can tell when a full output row has finished. Both the product input and the partial-sum output use valid/ready handshakes.

## Interface
- PROD_WIDTH, 8: width of each unsigned product from the multiplier.
- ACC_WIDTH, 12: width of the accumulator and of psum_data.
  - Must be ≥ PROD_WIDTH.
- DEPTH_F, 3: products per window.
  - Must be ≥ 1.
- NUM_OUT, 3: windows per row (DEPTH_I − DEPTH_F + 1).
  - Must be ≥ 1.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- prod_data  input  PROD_WIDTH  incoming product, unsigned.
- prod_valid  input  1  prod_data is valid.
- prod_ready  output  1  block accepts a product this cycle.
- psum_data  output  ACC_WIDTH  completed window sum.
- psum_valid  output  1  psum_data is valid.
- psum_ready  input  1  consumer accepts psum_data this cycle.
- psum_last  output  1  qualifies psum_valid; high on the NUM_OUT-th window of a row.
- busy  output  1  high when at least one product of the current window has been accepted.

## Operation
- A handshake occurs on a cycle where valid and ready are both high at the rising edge.
- State machine has two states, ACC and OUT.
- ACC:
  - prod_ready = 1, psum_valid = 0.
  - On each product handshake:
    - acc ← prod_data zero-extended when win_cnt = 0, otherwise acc + prod_data.
    - win_cnt increments.
  - On the handshake that makes win_cnt reach DEPTH_F:
    - psum_data ← the new sum.
    - win_cnt ← 0.
    - Next state is OUT.
- OUT:
  - prod_ready = 0, psum_valid = 1.
  - psum_data and psum_last are held stable until the output handshake.
  - On the psum handshake:
    - Next state is ACC.
    - row_cnt increments; it wraps to 0 after NUM_OUT − 1.
- psum_last = psum_valid && (row_cnt == NUM_OUT − 1).
- busy = (win_cnt != 0).
- Arithmetic:
  - Unsigned.
  - Sum width is ACC_WIDTH.
  - Overflow handling is set by the Configuration section.
- Input handling:
  - prod_valid while in OUT is ignored; the product stays pending upstream.
  - No input is dropped and no input is double-counted.
- Reset (asynchronous, valid at any time, including mid-window or in OUT):
  - State → ACC; acc, win_cnt, row_cnt → 0.
  - psum_data → 0; psum_valid → 0; psum_last → 0; busy → 0.
  - prod_ready → 1 after reset deasserts.
  - A partial window is discarded.

## Timing
- Latency: psum_valid rises in the cycle after the DEPTH_F-th product handshake.
- Maximum throughput is one psum per DEPTH_F + 1 cycles.
  - There is no overlap: the block does not accept a product in the same cycle as a psum handshake.
- prod_ready and psum_valid are pure functions of state; they have no combinational path from the inputs.
- Backpressure: while psum_ready is low, the block stays in OUT indefinitely with outputs frozen.
- DEPTH_F = 1: every product handshake goes directly to OUT with psum_data = the zero-extended product.

## Configuration
- PSUM_ACC_SATURATE_EN:
  - Defined: each addition clamps to 2^ACC_WIDTH − 1 on overflow.
    - Once clamped, the value stays clamped for the rest of the window.
  - Undefined: additions wrap modulo 2^ACC_WIDTH.
  - No other behaviour differs between the two builds.

## Test plan
- Basic window:
  - Stimulus: defaults; products 1, 4, 9; psum_ready held high.
  - Required: psum_data = 14 with psum_valid one cycle after the 3rd handshake; psum_last = 0.
- Full row:
  - Stimulus: products 0,1,4 / 1,4,9 / 4,9,16.
  - Required: psums 5, 14, 29; psum_last only on 29.
  - Then 1,1,1 → psum 3 with psum_last = 0, confirming row_cnt wrapped.
- Backpressure:
  - Stimulus: after products 2, 3, 5, hold psum_ready low for 5 cycles while prod_valid stays high with data 7.
  - Required: psum_data = 10 stable and prod_ready = 0 throughout.
  - After release, the 7 is accepted in the next ACC cycle.
- Overflow:
  - Stimulus: ACC_WIDTH = 9; products 255, 255, 255.
  - Required: psum = 253 without PSUM_ACC_SATURATE_EN; psum = 511 with it.
- Reset mid-window:
  - Stimulus: after products 6, 6, assert reset for 1 cycle, then send 1, 2, 3.
  - Required: all outputs 0 during reset; busy = 0 after reset; psum = 6; row_cnt restarted, so psum_last = 0.
- Reset in OUT:
  - Stimulus: reset while psum_valid = 1.
  - Required: psum_valid drops asynchronously; no psum handshake is recorded.
